// File: rtl/niu32_key_sw_reader.sv
// niu32_key_sw_reader
// Board input peripheral for the Niu32 core. KEY[3:0] and SW[9:0] are
// synchronized and debounced here. Key presses are latched as sticky flags
// that can raise an interrupt. The core sees four 32-bit registers:
//   0x0 KEYS (R)      debounced key state, 1 = pressed
//   0x4 SWS  (R)      debounced switch state
//   0x8 EDGE (R/W1C)  sticky key-press flags
//   0xC IE   (R/W)    per-key interrupt enable
module niu32_key_sw_reader #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic        CLOCK_50,
   input  logic        RESET,
   input  logic [3:0]  KEY,
   input  logic [9:0]  SW,
   input  logic [3:0]  addr,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        irq
);

   // Debounced bits. Bits [3:0] are the keys (already inverted) and bits [13:4] are the switches.
   localparam int NB = 14;
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      REG_KEYS = 2'd0,
      REG_SWS  = 2'd1,
      REG_EDGE = 2'd2,
      REG_IE   = 2'd3
   } reg_sel_t;

   logic [3:0]    key_s1, key_s2;
   logic [9:0]    sw_s1, sw_s2;
   logic [NB-1:0] sync_vec;
   logic [NB-1:0] stb, stb_next;
   logic [CW-1:0] cnt      [NB];
   logic [CW-1:0] cnt_next [NB];
   logic [3:0]    key_rise;
   logic [3:0]    edge_flags, edge_next;
   logic [3:0]    ie_mask, ie_next;
   logic [3:0]    edge_clr;
   logic [31:0]   rd_value;
   reg_sel_t      reg_sel;

   // The register select uses only the word address. Byte offsets and the upper write-data bits are not used.
   logic unused_bits;
   assign unused_bits = ^{addr[1:0], wdata[31:4]};

   assign reg_sel  = reg_sel_t'(addr[3:2]);
   assign sync_vec = {sw_s2, ~key_s2};

   // Two-flop synchronizers. The key stages reset to "released" (1).
   always_ff @(posedge CLOCK_50) begin
      // NOTE: state registers use non-blocking assignments so that every flop samples values from before the edge.
      if (RESET) begin
         key_s1 <= 4'hF;
         key_s2 <= 4'hF;
         sw_s1  <= '0;
         sw_s2  <= '0;
      end else begin
         key_s1 <= KEY;
         key_s2 <= key_s1;
         sw_s1  <= SW;
         sw_s2  <= sw_s1;
      end
   end

   // Per-bit debounce. The counter tracks how many consecutive samples disagree with stb.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves a value unassigned and no latch is inferred.
      stb_next = stb;
      for (int i = 0; i < NB; i++) begin
         cnt_next[i] = '0;
         if (sync_vec[i] != stb[i]) begin
            if (cnt[i] == CNT_LAST) begin
               stb_next[i] = sync_vec[i];
            end else begin
               cnt_next[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         stb <= '0;
         // NOTE: the counter array sits in flops and is small, so it is reset like any other register. A reset must discard debounce progress.
         for (int i = 0; i < NB; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         stb <= stb_next;
         for (int i = 0; i < NB; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   // Sticky flags and interrupt enable. A new press overrides a W1C clear on the same edge.
   always_comb begin
      key_rise  = stb_next[3:0] & ~stb[3:0];
      edge_clr  = (wr_en && reg_sel == REG_EDGE) ? wdata[3:0] : 4'h0;
      edge_next = (edge_flags & ~edge_clr) | key_rise;
      ie_next   = (wr_en && reg_sel == REG_IE) ? wdata[3:0] : ie_mask;
   end

   // Read mux. It shows register contents from before any write on the same edge.
   always_comb begin
      rd_value = '0;
      case (reg_sel)
         REG_KEYS: rd_value = {28'h0, stb[3:0]};
         REG_SWS:  rd_value = {22'h0, stb[13:4]};
         REG_EDGE: rd_value = {28'h0, edge_flags};
         REG_IE:   rd_value = {28'h0, ie_mask};
         default:  rd_value = '0;
      endcase
   end

   // Flag, enable and interrupt registers, plus the registered bus read port.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         edge_flags  <= '0;
         ie_mask     <= '0;
         irq         <= 1'b0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else begin
         edge_flags  <= edge_next;
         ie_mask     <= ie_next;
         irq         <= |(edge_next & ie_next);
         rdata_valid <= rd_en;
         if (rd_en) begin
            rdata <= rd_value;
         end
      end
   end

endmodule

// File: tb/tb_niu32_key_sw_reader.sv
// Testbench for niu32_key_sw_reader with DEBOUNCE_CYCLES = 4.
// The reference model follows the register-level behaviour. It tracks the run
// length of each synchronized sample stream, and a debounced bit flips once
// DEBOUNCE_CYCLES consecutive samples disagree with it.
module tb_niu32_key_sw_reader;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  key_in;
   logic [9:0]  sw_in;
   logic [3:0]  addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        irq;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic [13:0] m_p1, m_p2;       // raw {SW, KEY} pin pipeline
   logic [13:0] m_stb;            // {sws, keys pressed}
   int          m_run  [14];
   logic        m_runv [14];
   logic [3:0]  m_edge, m_ie;
   logic        m_irq, m_valid;
   logic [31:0] m_rdata;

   niu32_key_sw_reader #(.DEBOUNCE_CYCLES(D)) dut (
      .CLOCK_50    (clk),
      .RESET       (reset),
      .KEY         (key_in),
      .SW          (sw_in),
      .addr        (addr),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .wdata       (wdata),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance the model by one rising edge, using the inputs the DUT sees at that edge.
   task automatic model_step();
      logic [13:0] s;
      logic [13:0] old_stb;
      logic [31:0] rd;
      logic [3:0]  clr;
      if (reset) begin
         m_p1 = {10'h0, 4'hF};
         m_p2 = {10'h0, 4'hF};
         m_stb = '0;
         for (int i = 0; i < 14; i++) begin
            m_run[i]  = 0;
            m_runv[i] = 1'b0;
         end
         m_edge = '0; m_ie = '0; m_irq = 1'b0; m_valid = 1'b0; m_rdata = '0;
         return;
      end
      s = {m_p2[13:4], ~m_p2[3:0]};
      old_stb = m_stb;
      case (addr[3:2])
         2'd0: rd = {28'h0, m_stb[3:0]};
         2'd1: rd = {22'h0, m_stb[13:4]};
         2'd2: rd = {28'h0, m_edge};
         default: rd = {28'h0, m_ie};
      endcase
      for (int i = 0; i < 14; i++) begin
         if (s[i] === m_runv[i]) m_run[i]++;
         else begin
            m_run[i]  = 1;
            m_runv[i] = s[i];
         end
         if (s[i] != m_stb[i] && m_run[i] >= D) m_stb[i] = s[i];
      end
      clr = (wr_en && addr[3:2] == 2'd2) ? wdata[3:0] : 4'h0;
      m_edge = (m_edge & ~clr) | (m_stb[3:0] & ~old_stb[3:0]);
      if (wr_en && addr[3:2] == 2'd3) m_ie = wdata[3:0];
      m_irq = |(m_edge & m_ie);
      if (rd_en) m_rdata = rd;
      m_valid = rd_en;
      m_p2 = m_p1;
      m_p1 = {sw_in, key_in};
   endtask

   // One clock: update the model at the rising edge, then compare outputs at the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("irq", {31'h0, irq}, {31'h0, m_irq});
      check("rdata_valid", {31'h0, rdata_valid}, {31'h0, m_valid});
      check("rdata", rdata, m_rdata);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
      addr = a; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check(tag, rdata, exp);
   endtask

   initial begin
      int hold;
      reset = 1'b1; key_in = 4'hF; sw_in = '0; addr = '0;
      rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
      hold = 0;

      // Reset state
      repeat (3) tick();
      reset = 1'b0;
      check("reset_irq", {31'h0, irq}, 32'h0);
      check("reset_valid", {31'h0, rdata_valid}, 32'h0);
      bus_read("reset_keys", 4'h0, 32'h0);
      bus_read("reset_sws",  4'h4, 32'h0);
      bus_read("reset_edge", 4'h8, 32'h0);
      bus_read("reset_ie",   4'hC, 32'h0);

      // KEY[0] press: KEYS[0] and EDGE[0] set on the 6th edge, with irq enabled by IE=1
      bus_write(4'hC, 32'h1);
      key_in[0] = 1'b0;
      repeat (5) tick();
      check("press_irq_early", {31'h0, irq}, 32'h0);
      bus_read("press_keys_edge6", 4'h0, 32'h0);
      check("press_irq", {31'h0, irq}, 32'h1);
      bus_read("press_keys", 4'h0, 32'h1);
      bus_read("press_edge", 4'h8, 32'h1);

      // A glitch on KEY[1] lasting 3 cycles is rejected
      key_in[1] = 1'b0;
      repeat (3) tick();
      key_in[1] = 1'b1;
      repeat (8) tick();
      bus_read("glitch_keys", 4'h0, 32'h1);
      bus_read("glitch_edge", 4'h8, 32'h1);

      // W1C on EDGE
      key_in[1] = 1'b0;
      repeat (8) tick();
      bus_read("edge_both", 4'h8, 32'h3);
      bus_write(4'h8, 32'h1);
      bus_read("edge_w1c", 4'h8, 32'h2);
      key_in[0] = 1'b1;
      repeat (8) tick();
      bus_read("release_keys", 4'h0, 32'h2);
      bus_read("release_edge", 4'h8, 32'h2);
      // A fresh press on KEY[0] lands on the same edge as a clear of bit 0; the set wins
      key_in[0] = 1'b0;
      repeat (5) tick();
      bus_write(4'h8, 32'h1);
      bus_read("set_beats_clear", 4'h8, 32'h3);

      // Switches
      sw_in = 10'h2A5;
      repeat (4) tick();
      bus_read("sws_early", 4'h4, 32'h0);
      bus_read("sws_edge6", 4'h4, 32'h0);
      bus_read("sws_value", 4'h4, 32'h2A5);
      bus_read("sws_edge_unchanged", 4'h8, 32'h3);

      // Simultaneous read and write of IE returns the value from before the write
      bus_write(4'hC, 32'hF);
      check("ie_irq_on", {31'h0, irq}, 32'h1);
      addr = 4'hC; wdata = 32'h0; rd_en = 1'b1; wr_en = 1'b1;
      tick();
      rd_en = 1'b0; wr_en = 1'b0;
      check("rdwr_rdata", rdata, 32'hF);
      check("rdwr_irq_off", {31'h0, irq}, 32'h0);
      bus_read("rdwr_ie_after", 4'hC, 32'h0);

      // Reset in the middle of a debounce, with KEY[2] held through it
      key_in = 4'hF;
      repeat (8) tick();
      key_in[2] = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_reset_rdata", rdata, 32'h0);
      bus_read("mid_reset_keys", 4'h0, 32'h0);
      bus_read("mid_reset_sws",  4'h4, 32'h0);
      bus_read("mid_reset_edge", 4'h8, 32'h0);
      bus_read("mid_reset_ie",   4'hC, 32'h0);
      repeat (2) tick();
      bus_read("post_reset_keys", 4'h0, 32'h4);
      bus_read("post_reset_edge", 4'h8, 32'h4);
      bus_read("post_reset_sws",  4'h4, 32'h2A5);

      // Randomized pins and bus traffic, checked every cycle against the model
      for (int n = 0; n < 600; n++) begin
         if (hold == 0) begin
            key_in = 4'($urandom);
            sw_in  = 10'($urandom);
            hold   = $urandom_range(1, 7);
         end
         hold--;
         addr  = 4'($urandom);
         wdata = $urandom;
         rd_en = ($urandom_range(0, 2) == 0);
         wr_en = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 149) == 0);
         tick();
      end
      reset = 1'b0; rd_en = 1'b0; wr_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
